// File: rtl/instr_mem_loader.sv
// Serial boot loader: frames a byte stream as LEN(16) + 4*N payload bytes + XOR checksum,
// writes little-endian words to instruction memory and releases the CPU only on a good frame.
module instr_mem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready; rx_ready is a
  // flop driven from the next state, so it never depends combinationally on rx_valid.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state;
  state_t      next_state;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic        accept;
  logic        arm;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign arm       = start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign len_full  = {rx_data, len[7:0]};
  assign last_word = (words_loaded + 16'd1) == len;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN0;
      S_LEN0: if (accept) next_state = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (len_full > DEPTH16)     next_state = S_ERR;
          else if (len_full == 16'd0) next_state = S_CSUM;
          else                        next_state = S_DATA;
        end
      end
      S_DATA: if (accept && byte_idx == 2'd3 && last_word) next_state = S_CSUM;
      S_CSUM: if (accept) next_state = (rx_data == csum) ? S_DONE : S_ERR;
      default: next_state = S_IDLE;
    endcase
  end

  // Status flags are registered copies of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      rx_ready  <= next_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
      busy      <= next_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
      done      <= next_state == S_DONE;
      error     <= next_state == S_ERR;
      cpu_reset <= next_state != S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len          <= '0;
      csum         <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (arm) begin
        len          <= '0;
        csum         <= '0;
        byte_idx     <= '0;
        mem_waddr    <= '0;
        words_loaded <= '0;
      end else if (accept) begin
        case (state)
          S_LEN0: begin
            len[7:0] <= rx_data;
            csum     <= csum ^ rx_data;
          end
          S_LEN1: begin
            len[15:8] <= rx_data;
            csum      <= csum ^ rx_data;
          end
          S_DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // Write issues the cycle after the fourth byte; count moves on the same edge.
                mem_we       <= 1'b1;
                mem_wdata    <= {rx_data, word_buf};
                mem_waddr    <= words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: frames are scored by a byte-level frame model
// (length, payload words, XOR checksum) and memory writes are matched against a queue.
module tb_instr_mem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;
  logic [2:0]        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      if (exp_q.size() == 0) check("unexpected_write", {mem_waddr, mem_wdata}, '0);
      else                   check("write", {mem_waddr, mem_wdata}, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered and left on a falling edge; returns one cycle after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int waited = 0;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = noise && (g == 0);
      rx_data = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("rx_ready_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // ---------------- reference model + frame runner ----------------
  task automatic run_frame(input int gap_max, input bit noise);
    int n, consumed, nw;
    bit len_bad, ok;
    logic [7:0] x;
    n = {frame_q[1], frame_q[0]};
    len_bad = n > DEPTH;
    consumed = len_bad ? 2 : frame_q.size();
    x = 8'h00;
    for (int i = 0; i < frame_q.size() - 1; i++) x ^= frame_q[i];
    ok = !len_bad && (x == frame_q[frame_q.size() - 1]);
    if (!len_bad)
      for (int w = 0; w < n; w++)
        exp_q.push_back({ADDR_W'(w), frame_q[2+4*w+3], frame_q[2+4*w+2],
                         frame_q[2+4*w+1], frame_q[2+4*w]});
    pulse_start();
    check("busy_after_start", busy, 1);
    check("cpu_reset_after_start", cpu_reset, 1);
    for (int i = 0; i < consumed; i++) begin
      send_byte(frame_q[i], (i > 0 && gap_max > 0) ? $urandom_range(1, gap_max) : 0, noise);
      if (i >= 2 && i < consumed - 1 && ((i - 2) % 4) == 3) begin
        nw = (i - 2) / 4 + 1;
        check("write_latency", mem_we, 1);
        check("words_progress", words_loaded, nw);
      end
    end
    check("done", done, ok);
    check("error", error, !ok);
    check("cpu_reset", cpu_reset, !ok);
    check("busy_end", busy, 0);
    check("rx_ready_end", rx_ready, 0);
    check("words_loaded", words_loaded, len_bad ? 0 : n);
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic load_fixed(input logic [7:0] last);
    frame_q = '{8'h03, 8'h00, 8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h05, 8'h20, 8'h80, 8'hE2,
                8'h0C, 8'h30, 8'h80, 8'hE2, last};
  endtask

  task automatic build_random(input int n, input bit bad_csum);
    logic [7:0] x, b;
    frame_q.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    x = n[7:0] ^ n[15:8];
    if (n <= DEPTH)
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        frame_q.push_back(b);
        x ^= b;
      end
    frame_q.push_back(bad_csum ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_flags", {busy, done, error}, 0);
    check("rst_words", words_loaded, 0);
    reset_n = 1'b1;
    @(negedge clk);

    load_fixed(8'hBA); run_frame(0, 0);          // good frame
    load_fixed(8'hBB); run_frame(0, 0);          // bad checksum, writes still happen
    frame_q = '{8'h41, 8'h00, 8'h00}; run_frame(0, 0);  // N = DEPTH+1
    frame_q = '{8'h00, 8'h00, 8'h00}; run_frame(0, 0);  // empty frame, good
    frame_q = '{8'h00, 8'h00, 8'h01}; run_frame(0, 0);  // empty frame, bad
    load_fixed(8'hBA); run_frame(3, 1);          // gaps plus ignored start pulses
    build_random(DEPTH, 0); run_frame(0, 0);     // full memory, last address DEPTH-1

    // Reset in the middle of the second word
    load_fixed(8'hBA);
    exp_q.push_back({ADDR_W'(0), 32'hE04F000F});
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0, 0);
    #3 reset_n = 1'b0;
    #1;
    check("arst_outputs", {rx_ready, mem_we, busy, done, error, cpu_reset}, 6'b000001);
    check("arst_addr_data", {mem_waddr, mem_wdata}, 0);
    check("arst_words", words_loaded, 0);
    check("arst_first_write_seen", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(0, 0);

    for (int t = 0; t < 10; t++) begin
      int n;
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(DEPTH + 1, 300);
        1:       n = $urandom_range(0, 2);
        default: n = $urandom_range(1, DEPTH);
      endcase
      build_random(n, $urandom_range(0, 2) == 0);
      run_frame($urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
